mult_bcd_seq: RTL and testbench

MULT_BCD_SEQ -- requirements
Module: mult_bcd_seq

---
 rtl/mult_bcd_seq.sv | 126 ++++++++++++
 tb/tb_mult_bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_bcd_seq.sv
// Sequential shift-add multiplier followed by a double-dabble binary-to-BCD converter.
// One operation takes 3*W clocks from the accepted start edge to the done cycle.
module mult_bcd_seq #(
  parameter int W    = 8,
  parameter int NDIG = 5
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                start,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic [2*W-1:0]      p,
  output logic [4*NDIG-1:0]   p_BCD,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  // Handshake: start is a request sampled only while idle (busy=0); it is
  // dropped silently otherwise. done pulses for exactly one cycle, and p/p_BCD
  // are updated in that cycle and hold until the next done.

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_P = ((64'd1 << W) - 1) * ((64'd1 << W) - 1);
  localparam int CW = $clog2(2 * W + 1);

  generate
    if (pow10(NDIG) <= MAX_P) begin : g_param_check
      $error("mult_bcd_seq: NDIG too small to hold (2^W-1)^2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      a_q, b_q;
  logic [2*W-1:0]    acc;
  logic [4*NDIG-1:0] dig, dig_adj, dig_shift;
  logic              mul_last, bcd_last, next_bit;

  assign mul_last  = (cnt == CW'(W - 1));
  assign bcd_last  = (cnt == CW'(2 * W - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // The product MSB-first feed is picked by the counter so acc stays intact for p.
  assign next_bit  = |(acc & ({1'b1, {(2*W-1){1'b0}}} >> cnt));

  always_comb begin
    dig_adj = dig;
    for (int i = 0; i < NDIG; i++) begin
      if (dig[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
    end
  end

  assign dig_shift = (dig_adj << 1) | {{(4*NDIG-1){1'b0}}, next_bit};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = BCD;
      BCD:     if (bcd_last) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      dig   <= '0;
      p     <= '0;
      p_BCD <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            dig <= '0;
            cnt <= '0;
          end
        end
        MUL: begin
          if (b_q[0]) acc <= acc + ({{W{1'b0}}, a_q} << cnt);
          b_q <= b_q >> 1;
          cnt <= mul_last ? '0 : cnt + CW'(1);
        end
        BCD: begin
          dig <= dig_shift;
          cnt <= bcd_last ? '0 : cnt + CW'(1);
          if (bcd_last) begin
            p     <= acc;
            p_BCD <= dig_shift;
          end
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_bcd_seq.sv
// Directed + random checks of mult_bcd_seq at W=8/NDIG=5 and W=4/NDIG=3 against
// a plain-arithmetic product and decimal-digit model.
module tb_mult_bcd_seq;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clrn = 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic [19:0] bcd8;
  logic        busy8, done8;
  logic [1:0]  st8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;
  logic [11:0] bcd4;
  logic        busy4, done4;
  logic [1:0]  st4;

  mult_bcd_seq #(.W(8), .NDIG(5)) dut8 (
    .clk(clk), .clrn(clrn), .start(start8), .a(a8), .b(b8),
    .p(p8), .p_BCD(bcd8), .busy(busy8), .done(done8), .state_dbg(st8)
  );

  mult_bcd_seq #(.W(4), .NDIG(3)) dut4 (
    .clk(clk), .clrn(clrn), .start(start4), .a(a4), .b(b4),
    .p(p4), .p_BCD(bcd4), .busy(busy4), .done(done4), .state_dbg(st4)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int k_cyc    = 0;
  longint unsigned last_p8 = 0;
  logic [63:0] exp_q[$];

  // reference model: decimal digits by repeated division
  function automatic logic [63:0] to_bcd(input longint unsigned v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks; all called and returning on a negative edge
  task automatic go8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k_cyc = cyc;
    chk("busy_after_start8", 64'(busy8), 64'd1);
  endtask

  task automatic wait_done8(input string tag, input longint unsigned exp_p);
    while (!done8 && (cyc - k_cyc) < 100) begin
      if ((cyc - k_cyc) == 16) chk({tag, "_hold_p"}, 64'(p8), 64'(last_p8));
      if (!busy8) chk({tag, "_busy_drop"}, 64'(busy8), 64'd1);
      @(negedge clk);
    end
    exp_q.push_back(64'(exp_p));
    chk({tag, "_latency"}, 64'(cyc - k_cyc), 64'd24);
    chk({tag, "_p"}, 64'(p8), exp_q.pop_front());
    chk({tag, "_bcd"}, 64'(bcd8), to_bcd(exp_p, 5));
    last_p8 = exp_p;
    @(negedge clk);
    chk({tag, "_after_done"}, {62'd0, done8, busy8}, 64'd0);
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b);
    longint unsigned e;
    e = longint'(a) * longint'(b);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k_cyc = cyc;
    chk({tag, "_busy"}, 64'(busy4), 64'd1);
    while (!done4 && (cyc - k_cyc) < 60) @(negedge clk);
    chk({tag, "_latency"}, 64'(cyc - k_cyc), 64'd12);
    chk({tag, "_p"}, 64'(p4), 64'(e));
    chk({tag, "_bcd"}, 64'(bcd4), to_bcd(e, 3));
    @(negedge clk);
    chk({tag, "_after_done"}, {62'd0, done4, busy4}, 64'd0);
  endtask

  initial begin : stimulus
    int pulses;
    logic [7:0] ra, rb;
    logic [3:0] ra4, rb4;

    // asynchronous reset with start high, checked before any clock edge
    #1;
    start8 = 1'b1; start4 = 1'b1; a8 = 8'd5; b8 = 8'd5; a4 = 4'd3; b4 = 4'd3;
    clrn = 1'b0;
    #1;
    chk("rst_p8", 64'(p8), 64'd0);
    chk("rst_bcd8", 64'(bcd8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_state8", 64'(st8), 64'd0);
    chk("rst_p4", 64'(p4), 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_busy8", 64'(busy8), 64'd0);
    chk("rst_hold_busy4", 64'(busy4), 64'd0);
    start8 = 1'b0; start4 = 1'b0;
    clrn = 1'b1;
    @(negedge clk);

    // basic
    go8(8'd1, 8'd1);
    wait_done8("basic", 1);

    // operand latch and start ignored while busy
    go8(8'd254, 8'd11);
    @(negedge clk);
    a8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("latch", 2794);
    @(negedge clk);
    chk("no_queue_busy", 64'(busy8), 64'd0);

    // zero operand
    go8(8'd0, 8'd200);
    wait_done8("zero8", 0);

    // maximum with start held high: back-to-back with one idle cycle
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(negedge clk);
    k_cyc = cyc;
    chk("max_busy", 64'(busy8), 64'd1);
    wait_done8("max1", 65025);
    @(negedge clk);
    chk("held_restart_busy", 64'(busy8), 64'd1);
    k_cyc = cyc;
    start8 = 1'b0;
    wait_done8("max2", 65025);

    // reset ten clocks into BCD
    go8(8'd150, 8'd40);
    while ((cyc - k_cyc) < 18) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_p", 64'(p8), 64'd0);
    chk("midrst_bcd", 64'(bcd8), 64'd0);
    chk("midrst_busy", 64'(busy8), 64'd0);
    last_p8 = 0;
    @(negedge clk);
    clrn = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    go8(8'd35, 8'd20);
    wait_done8("after_rst", 700);

    // random operands
    repeat (6) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      go8(ra, rb);
      wait_done8("rand8", longint'(ra) * longint'(rb));
    end

    // narrow instance
    run4("w4_max", 4'd15, 4'd15);
    run4("w4_zero", 4'd0, 4'd9);
    repeat (4) begin
      ra4 = 4'($urandom_range(0, 15));
      rb4 = 4'($urandom_range(0, 15));
      run4("w4_rand", ra4, rb4);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
